// File: rtl/ctrl_sequencer_if.sv
`default_nettype none
//============================================================================
// Module      : ctrl_sequencer_if
// Description : Control-strobe bundle between the hardwired sequencer and
//               the CPU datapath. The sequencer reads back the IR contents
//               and drives every datapath control strobe.
//
//   ir         datapath -> sequencer  current instruction register contents
//   Rin        sequencer -> datapath  one-hot register load strobes
//   Rout       sequencer -> datapath  one-hot register bus-drive strobes
//   PCout .. Cout                     single-bit datapath strobes
//   ALUselect  sequencer -> datapath  ALU operation code
//   halted     sequencer -> system    high while parked in HALT
//   retired    sequencer -> system    completed-instruction counter
//
// Revision    : 1.0  initial release
//============================================================================
interface ctrl_sequencer_if;
    logic [31:0] ir;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic        PCout;
    logic        IncPC;
    logic        MARin;
    logic        MDRread;
    logic        MDRin;
    logic        MDRout;
    logic        IRin;
    logic        Yin;
    logic        Zin;
    logic        ZLowout;
    logic        Cout;
    logic [3:0]  ALUselect;
    logic        halted;
    logic [15:0] retired;

    // Sequencer side.
    modport master (
        input  ir,
        output Rin, Rout, PCout, IncPC, MARin, MDRread, MDRin, MDRout,
               IRin, Yin, Zin, ZLowout, Cout, ALUselect, halted, retired
    );

    // Datapath side.
    modport slave (
        output ir,
        input  Rin, Rout, PCout, IncPC, MARin, MDRread, MDRin, MDRout,
               IRin, Yin, Zin, ZLowout, Cout, ALUselect, halted, retired
    );
endinterface : ctrl_sequencer_if
`default_nettype wire

// File: rtl/ctrl_sequencer.sv
`default_nettype none
//============================================================================
// Module      : ctrl_sequencer
// Description : Hardwired multi-cycle control unit. Sequences instruction
//               fetch (T0..T2) and executes R-format ALU, I-format ALU, nop
//               and halt instructions (T3..T5) by decoding the IR contents
//               read back from the datapath. Unknown opcodes execute as nop.
//
// Ports
//   clk   system clock, all state changes on the rising edge
//   clr   synchronous active-high reset
//   bus   ctrl_sequencer_if.master : ir in, all datapath strobes out,
//         halted flag and 16-bit retired-instruction counter
//
// Parameters
//   MEM_WAIT  extra cycles T1 is held for memory latency (0..7)
//
// Revision    : 1.0  initial release
//============================================================================
module ctrl_sequencer #(
    parameter int MEM_WAIT = 0
) (
    input  wire logic         clk,
    input  wire logic         clr,
    ctrl_sequencer_if.master  bus
);

    //------------------------------------------------------------------------
    // Opcodes
    //------------------------------------------------------------------------
    localparam logic [4:0] c_op_add  = 5'b00011;
    localparam logic [4:0] c_op_sub  = 5'b00100;
    localparam logic [4:0] c_op_and  = 5'b00101;
    localparam logic [4:0] c_op_or   = 5'b00110;
    localparam logic [4:0] c_op_shr  = 5'b01000;
    localparam logic [4:0] c_op_shl  = 5'b01001;
    localparam logic [4:0] c_op_addi = 5'b01100;
    localparam logic [4:0] c_op_andi = 5'b01101;
    localparam logic [4:0] c_op_ori  = 5'b01110;
    localparam logic [4:0] c_op_halt = 5'b11011;

    // Last value of the wait counter before leaving T1. The counter is
    // three bits wide, which bounds MEM_WAIT to 0..7.
    localparam logic [2:0] c_wait_last = 3'(MEM_WAIT);

    //------------------------------------------------------------------------
    // State encoding
    //------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_RST  = 3'd0,
        ST_T0   = 3'd1,
        ST_T1   = 3'd2,
        ST_T2   = 3'd3,
        ST_T3   = 3'd4,
        ST_T4   = 3'd5,
        ST_T5   = 3'd6,
        ST_HALT = 3'd7
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_wait_cnt;
    logic [2:0]  w_wait_next;
    logic [15:0] r_retired;
    logic        w_retire;

    //------------------------------------------------------------------------
    // IR field decode
    //------------------------------------------------------------------------
    logic [4:0]  w_op;
    logic [3:0]  w_ra;
    logic [3:0]  w_rb;
    logic [3:0]  w_rc;
    logic        w_is_r;
    logic        w_is_i;
    logic        w_is_halt;
    logic [3:0]  w_alu_code;
    logic [15:0] w_ra_onehot;
    logic [15:0] w_rb_onehot;
    logic [15:0] w_rc_onehot;
    logic        w_unused_ir;

    assign w_op = bus.ir[31:27];
    assign w_ra = bus.ir[26:23];
    assign w_rb = bus.ir[22:19];
    assign w_rc = bus.ir[18:15];

    // Immediate / low IR bits belong to the datapath, not the sequencer.
    assign w_unused_ir = ^bus.ir[14:0];

    assign w_ra_onehot = 16'h0001 << w_ra;
    assign w_rb_onehot = 16'h0001 << w_rb;
    assign w_rc_onehot = 16'h0001 << w_rc;

    always_comb begin
        w_is_r     = 1'b0;
        w_is_i     = 1'b0;
        w_alu_code = 4'b0000;
        unique case (w_op)
            c_op_add:  begin w_is_r = 1'b1; w_alu_code = 4'b0000; end
            c_op_sub:  begin w_is_r = 1'b1; w_alu_code = 4'b0001; end
            c_op_and:  begin w_is_r = 1'b1; w_alu_code = 4'b0010; end
            c_op_or:   begin w_is_r = 1'b1; w_alu_code = 4'b0011; end
            c_op_shl:  begin w_is_r = 1'b1; w_alu_code = 4'b0100; end
            c_op_shr:  begin w_is_r = 1'b1; w_alu_code = 4'b0101; end
            c_op_addi: begin w_is_i = 1'b1; w_alu_code = 4'b0000; end
            c_op_andi: begin w_is_i = 1'b1; w_alu_code = 4'b0010; end
            c_op_ori:  begin w_is_i = 1'b1; w_alu_code = 4'b0011; end
            default:   begin w_is_r = 1'b0; w_is_i = 1'b0; end
        endcase
    end

    assign w_is_halt = (w_op == c_op_halt);

    //------------------------------------------------------------------------
    // State, wait counter and retired counter
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= ST_RST;
            r_wait_cnt <= 3'd0;
            r_retired  <= 16'd0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_next;
            if (w_retire) begin
                r_retired <= r_retired + 16'd1;   // wraps naturally
            end
        end
    end

    assign bus.retired = r_retired;

    //------------------------------------------------------------------------
    // Next state and Moore strobes (state plus the stable IR contents)
    //------------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_wait_next   = r_wait_cnt;
        w_retire      = 1'b0;

        bus.Rin       = 16'h0000;
        bus.Rout      = 16'h0000;
        bus.PCout     = 1'b0;
        bus.IncPC     = 1'b0;
        bus.MARin     = 1'b0;
        bus.MDRread   = 1'b0;
        bus.MDRin     = 1'b0;
        bus.MDRout    = 1'b0;
        bus.IRin      = 1'b0;
        bus.Yin       = 1'b0;
        bus.Zin       = 1'b0;
        bus.ZLowout   = 1'b0;
        bus.Cout      = 1'b0;
        bus.ALUselect = 4'b0000;
        bus.halted    = 1'b0;

        unique case (r_state)
            ST_RST: begin
                w_state_next = ST_T0;
            end

            ST_T0: begin
                bus.PCout    = 1'b1;
                bus.MARin    = 1'b1;
                bus.IncPC    = 1'b1;
                w_state_next = ST_T1;
            end

            // Memory read: held for 1+MEM_WAIT cycles. The counter is left
            // at zero on exit so the next fetch starts a fresh wait.
            ST_T1: begin
                bus.MDRread = 1'b1;
                bus.MDRin   = 1'b1;
                if (r_wait_cnt == c_wait_last) begin
                    w_wait_next  = 3'd0;
                    w_state_next = ST_T2;
                end else begin
                    w_wait_next  = r_wait_cnt + 3'd1;
                end
            end

            ST_T2: begin
                bus.MDRout   = 1'b1;
                bus.IRin     = 1'b1;
                w_state_next = ST_T3;
            end

            // First execute cycle: ALU instructions latch Rb into Y; halt
            // parks; everything else retires as a nop.
            ST_T3: begin
                if (w_is_r || w_is_i) begin
                    bus.Rout     = w_rb_onehot;
                    bus.Yin      = 1'b1;
                    w_state_next = ST_T4;
                end else if (w_is_halt) begin
                    w_state_next = ST_HALT;
                end else begin
                    w_retire     = 1'b1;
                    w_state_next = ST_T0;
                end
            end

            // Second operand: Rc for R-format, the sign-extended constant
            // (Cout) for I-format.
            ST_T4: begin
                bus.Zin       = 1'b1;
                bus.ALUselect = w_alu_code;
                if (w_is_r) begin
                    bus.Rout = w_rc_onehot;
                end else begin
                    bus.Cout = 1'b1;
                end
                w_state_next = ST_T5;
            end

            ST_T5: begin
                bus.ZLowout  = 1'b1;
                bus.Rin      = w_ra_onehot;
                w_retire     = 1'b1;
                w_state_next = ST_T0;
            end

            ST_HALT: begin
                bus.halted   = 1'b1;
                w_state_next = ST_HALT;
            end

            default: begin
                w_state_next = ST_RST;
            end
        endcase
    end

endmodule : ctrl_sequencer
`default_nettype wire

// File: tb/tb_ctrl_sequencer.sv
`default_nettype none
//============================================================================
// Module      : tb_ctrl_sequencer
// Description : Self-checking bench for ctrl_sequencer. Two instances are
//               exercised in turn: MEM_WAIT=0 and MEM_WAIT=2. Stimulus pushes
//               the hand-computed expected output vector for each cycle into
//               a queue; a monitor on the falling edge pops and compares.
//
// Revision    : 1.0  initial release
//============================================================================
module tb_ctrl_sequencer;

    logic clk;
    logic clr0;
    logic clr2;

    ctrl_sequencer_if if0 ();
    ctrl_sequencer_if if2 ();

    ctrl_sequencer #(.MEM_WAIT(0)) dut0 (.clk(clk), .clr(clr0), .bus(if0));
    ctrl_sequencer #(.MEM_WAIT(2)) dut2 (.clk(clk), .clr(clr2), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe vector order: PCout IncPC MARin MDRread MDRin MDRout IRin Yin
    // Zin ZLowout Cout (MSB first).
    localparam logic [10:0] S_NONE = 11'h000;
    localparam logic [10:0] S_T0   = 11'h700;
    localparam logic [10:0] S_T1   = 11'h0C0;
    localparam logic [10:0] S_T2   = 11'h030;
    localparam logic [10:0] S_YIN  = 11'h008;
    localparam logic [10:0] S_ZIN  = 11'h004;
    localparam logic [10:0] S_ZLOW = 11'h002;
    localparam logic [10:0] S_COUT = 11'h001;

    typedef struct {
        logic [127:0] name;
        bit           sel;
        logic [63:0]  v;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    //------------------------------------------------------------------------
    // Monitor: compares every queued expectation against the selected DUT.
    //------------------------------------------------------------------------
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [63:0] act;
            e = q.pop_front();
            if (e.sel)
                act = {if2.PCout, if2.IncPC, if2.MARin, if2.MDRread, if2.MDRin,
                       if2.MDRout, if2.IRin, if2.Yin, if2.Zin, if2.ZLowout,
                       if2.Cout, if2.Rin, if2.Rout, if2.ALUselect, if2.halted,
                       if2.retired};
            else
                act = {if0.PCout, if0.IncPC, if0.MARin, if0.MDRread, if0.MDRin,
                       if0.MDRout, if0.IRin, if0.Yin, if0.Zin, if0.ZLowout,
                       if0.Cout, if0.Rin, if0.Rout, if0.ALUselect, if0.halted,
                       if0.retired};
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %0s (dut%0d) t=%0t: got str=%h rin=%h rout=%h alu=%h halt=%b ret=%h, expected str=%h rin=%h rout=%h alu=%h halt=%b ret=%h",
                         e.name, e.sel ? 2 : 0, $time,
                         act[63:53], act[52:37], act[36:21], act[20:17], act[16], act[15:0],
                         e.v[63:53], e.v[52:37], e.v[36:21], e.v[20:17], e.v[16], e.v[15:0]);
            end
        end
    end

    //------------------------------------------------------------------------
    // Stimulus helpers
    //------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit sel, input logic [127:0] name,
                        input logic [10:0] str, input logic [15:0] rin,
                        input logic [15:0] rout, input logic [3:0] alu,
                        input logic halted, input logic [15:0] ret);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.v    = {str, rin, rout, alu, halted, ret};
        q.push_back(e);
    endtask

    task automatic cyc(input bit sel, input logic [127:0] name,
                       input logic [10:0] str, input logic [15:0] rin,
                       input logic [15:0] rout, input logic [3:0] alu,
                       input logic halted, input logic [15:0] ret);
        step();
        push(sel, name, str, rin, rout, alu, halted, ret);
    endtask

    // Steps into T0, presents the instruction, then T1 x(1+waits) and T2.
    task automatic fetch(input bit sel, input logic [31:0] instr,
                         input logic [15:0] ret, input int waits);
        step();
        if (sel) if2.ir = instr;
        else     if0.ir = instr;
        push(sel, "T0", S_T0, 16'h0, 16'h0, 4'h0, 1'b0, ret);
        for (int k = 0; k <= waits; k++)
            cyc(sel, "T1", S_T1, 16'h0, 16'h0, 4'h0, 1'b0, ret);
        cyc(sel, "T2", S_T2, 16'h0, 16'h0, 4'h0, 1'b0, ret);
    endtask

    task automatic alu_instr(input bit sel, input logic [31:0] instr,
                             input logic [15:0] rout_b, input logic [15:0] rout_c,
                             input logic use_c, input logic [3:0] alu,
                             input logic [15:0] rin_a, input logic [15:0] ret,
                             input int waits);
        fetch(sel, instr, ret, waits);
        cyc(sel, "T3_alu", S_YIN, 16'h0, rout_b, 4'h0, 1'b0, ret);
        cyc(sel, "T4_alu", use_c ? (S_ZIN | S_COUT) : S_ZIN, 16'h0, rout_c, alu, 1'b0, ret);
        cyc(sel, "T5_alu", S_ZLOW, rin_a, 16'h0, 4'h0, 1'b0, ret);
    endtask

    task automatic nop_instr(input logic [31:0] instr, input logic [15:0] ret);
        fetch(1'b0, instr, ret, 0);
        cyc(1'b0, "T3_nop", S_NONE, 16'h0, 16'h0, 4'h0, 1'b0, ret);
    endtask

    //------------------------------------------------------------------------
    // Directed sequence
    //------------------------------------------------------------------------
    initial begin
        clr0   = 1'b1;
        clr2   = 1'b1;
        if0.ir = 32'h0;
        if2.ir = 32'h0;

        // Reset state of both instances.
        repeat (2) begin
            cyc(1'b0, "rst0", S_NONE, 16'h0, 16'h0, 4'h0, 1'b0, 16'd0);
            push(1'b1, "rst2", S_NONE, 16'h0, 16'h0, 4'h0, 1'b0, 16'd0);
        end
        clr0 = 1'b0;

        // ---------------- MEM_WAIT = 0 ----------------
        // add r3,r1,r2
        alu_instr(1'b0, 32'h19890000, 16'h0002, 16'h0004, 1'b0, 4'b0000, 16'h0008, 16'd0, 0);
        // addi r5,r4,-3
        alu_instr(1'b0, 32'h62A7FFFD, 16'h0010, 16'h0000, 1'b1, 4'b0000, 16'h0020, 16'd1, 0);
        // shr r7,r6,r2
        alu_instr(1'b0, 32'h43B10000, 16'h0040, 16'h0004, 1'b0, 4'b0101, 16'h0080, 16'd2, 0);
        // ori r9,r10,5
        alu_instr(1'b0, 32'h74D00005, 16'h0400, 16'h0000, 1'b1, 4'b0011, 16'h0200, 16'd3, 0);
        // unknown opcode 11111 and nop
        nop_instr(32'hF8000000, 16'd4);
        nop_instr(32'hD0000000, 16'd5);
        // halt: T3 has no strobes, then parked
        fetch(1'b0, 32'hD8000000, 16'd6, 0);
        cyc(1'b0, "T3_halt", S_NONE, 16'h0, 16'h0, 4'h0, 1'b0, 16'd6);
        repeat (22) cyc(1'b0, "HALT", S_NONE, 16'h0, 16'h0, 4'h0, 1'b1, 16'd6);
        // clr pulse out of HALT
        clr0 = 1'b1;
        cyc(1'b0, "rst_from_halt", S_NONE, 16'h0, 16'h0, 4'h0, 1'b0, 16'd0);
        clr0 = 1'b0;
        // add aborted by clr during T4: no Rin for r3 ever appears
        fetch(1'b0, 32'h19890000, 16'd0, 0);
        cyc(1'b0, "T3_abort", S_YIN, 16'h0, 16'h0002, 4'h0, 1'b0, 16'd0);
        cyc(1'b0, "T4_abort", S_ZIN, 16'h0, 16'h0004, 4'b0000, 1'b0, 16'd0);
        clr0 = 1'b1;
        cyc(1'b0, "rst_from_T4", S_NONE, 16'h0, 16'h0, 4'h0, 1'b0, 16'd0);
        cyc(1'b0, "rst_hold", S_NONE, 16'h0, 16'h0, 4'h0, 1'b0, 16'd0);
        clr0 = 1'b0;
        nop_instr(32'hD0000000, 16'd0);
        step();
        push(1'b0, "T0_after_nop", S_T0, 16'h0, 16'h0, 4'h0, 1'b0, 16'd1);
        clr0 = 1'b1;

        // ---------------- MEM_WAIT = 2 ----------------
        clr2 = 1'b0;
        alu_instr(1'b1, 32'h19890000, 16'h0002, 16'h0004, 1'b0, 4'b0000, 16'h0008, 16'd0, 2);
        // clr in the middle of the T1 wait
        step();
        push(1'b1, "T0_w", S_T0, 16'h0, 16'h0, 4'h0, 1'b0, 16'd1);
        cyc(1'b1, "T1_w", S_T1, 16'h0, 16'h0, 4'h0, 1'b0, 16'd1);
        cyc(1'b1, "T1_w", S_T1, 16'h0, 16'h0, 4'h0, 1'b0, 16'd1);
        clr2 = 1'b1;
        cyc(1'b1, "rst_from_T1", S_NONE, 16'h0, 16'h0, 4'h0, 1'b0, 16'd0);
        clr2 = 1'b0;
        // full wait must be seen again after the abort
        alu_instr(1'b1, 32'h19890000, 16'h0002, 16'h0004, 1'b0, 4'b0000, 16'h0008, 16'd0, 2);
        step();
        push(1'b1, "T0_end", S_T0, 16'h0, 16'h0, 4'h0, 1'b0, 16'd1);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_ctrl_sequencer
`default_nettype wire
